// File: rtl/func_table_eval.sv
// Writable truth-table Boolean function unit.
// Streams evaluations and sweeps the table to count its minterms.
module func_table_eval #(
  parameter int N_IN = 4,
  parameter logic [2**N_IN-1:0] TT_INIT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [N_IN-1:0] cfg_addr,
  input  logic            cfg_data,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_f,
  input  logic            out_ready,
  input  logic            sweep_start,
  output logic            busy,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_count
);

  localparam int DEPTH = 2**N_IN;
  localparam logic [N_IN-1:0] IDX_ONE = N_IN'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e            state_q;
  logic [DEPTH-1:0]  tt_q;
  logic [N_IN-1:0]   idx_q;
  logic [N_IN:0]     acc_q;
  logic [N_IN:0]     cnt_q;
  logic              done_q;
  logic              ov_q;
  logic              of_q;
  logic [N_IN:0]     tt_bit;
  logic              accept;

  assign tt_bit = {{N_IN{1'b0}}, tt_q[idx_q]};

  assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid   = ov_q;
  assign out_f       = of_q;
  assign busy        = (state_q == SWEEP);
  assign sweep_done  = done_q;
  assign sweep_count = cnt_q;

  // Sweep FSM: walk every code, accumulate ones, publish the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sweep_start) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            acc_q   <= '0;
          end
        end
        SWEEP: begin
          acc_q <= acc_q + tt_bit;
          idx_q <= idx_q + IDX_ONE;
          if (&idx_q) begin
            cnt_q   <= acc_q + tt_bit;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Truth-table storage; writes are frozen while a sweep runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q <= TT_INIT;
    end else if (cfg_we && (state_q == IDLE)) begin
      tt_q[cfg_addr] <= cfg_data;
    end
  end

  // Output register: load on accept, drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      of_q <= 1'b0;
    end else if (accept) begin
      ov_q <= 1'b1;
      of_q <= tt_q[in_vec];
    end else if (out_ready) begin
      ov_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_func_table_eval.sv
// Bench for func_table_eval (N_IN = 4).
// Vector table, random model compare, and sweep sequences.
module tb_func_table_eval;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic       cfg_data;
  logic       in_valid;
  logic [3:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic       out_f;
  logic       out_ready;
  logic       sweep_start;
  logic       busy;
  logic       sweep_done;
  logic [4:0] sweep_count;

  func_table_eval #(
    .N_IN   (4),
    .TT_INIT(16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .in_valid   (in_valid),
    .in_vec     (in_vec),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_f      (out_f),
    .out_ready  (out_ready),
    .sweep_start(sweep_start),
    .busy       (busy),
    .sweep_done (sweep_done),
    .sweep_count(sweep_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;
    logic       f;
  } vec_t;

  vec_t        vtab[16];
  logic [15:0] mtt;
  int          n_chk;
  int          n_pass;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
    mtt[a]   = d;
  endtask

  task automatic load(input logic [15:0] t);
    for (int i = 0; i < 16; i++) wr(4'(i), t[i]);
  endtask

  task automatic eval1(input logic [3:0] v, input string nm);
    in_valid  = 1'b1;
    in_vec    = v;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_f"}, 32'(out_f), 32'(mtt[v]));
    tick();
  endtask

  // Runs one sweep; optional same-cycle write and mid-sweep write.
  task automatic sweep(input logic we0, input logic [3:0] a0,
                       input logic d0, input logic midw,
                       input string nm);
    int   cnt;
    logic rdy_seen;
    int   exp;
    sweep_start = 1'b1;
    cfg_we      = we0;
    cfg_addr    = a0;
    cfg_data    = d0;
    out_ready   = 1'b1;
    tick();
    sweep_start = 1'b0;
    cfg_we      = 1'b0;
    if (we0) mtt[a0] = d0;
    exp      = $countones(mtt);
    cnt      = 0;
    rdy_seen = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      cfg_we   = midw && (cnt == 2);
      cfg_addr = 4'd1;
      cfg_data = 1'b1;
      tick();
      cfg_we = 1'b0;
      cnt++;
    end
    check({nm, "_busy_cycles"}, 32'(cnt), 32'd16);
    check({nm, "_in_ready_low"}, 32'(rdy_seen), 32'd0);
    check({nm, "_done"}, 32'(sweep_done), 32'd1);
    check({nm, "_count"}, 32'(sweep_count), 32'(exp));
    tick();
    check({nm, "_done_pulse"}, 32'(sweep_done), 32'd0);
  endtask

  logic f_ref;
  logic mv;
  logic mf;
  logic m_rdy;

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    mtt         = 16'h0000;
    rst_n       = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = 4'd0;
    cfg_data    = 1'b0;
    in_valid    = 1'b0;
    in_vec      = 4'd0;
    out_ready   = 1'b1;
    sweep_start = 1'b0;

    for (int i = 0; i < 16; i++) begin
      logic a, b, c, d;
      {a, b, c, d} = 4'(i);
      vtab[i].vec = 4'(i);
      vtab[i].f   = (a & ((c & d) | b)) | (b & ~c);
    end

    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // make outputs non-zero, then reset asynchronously mid-cycle
    wr(4'd3, 1'b1);
    sweep(1'b0, 4'd0, 1'b0, 1'b0, "pre_sweep");
    in_valid  = 1'b1;
    in_vec    = 4'd3;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("pre_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    mtt = 16'h0000;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_f", 32'(out_f), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_count", 32'(sweep_count), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    eval1(4'd3, "post_rst_eval");

    // F830 back-to-back vector table
    load(16'hF830);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_vec = vtab[i].vec;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_f", i), 32'(out_f), 32'(vtab[i].f));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // backpressure
    in_valid  = 1'b1;
    in_vec    = 4'd12;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_f", 32'(out_f), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    sweep(1'b0, 4'd0, 1'b0, 1'b0, "sweep_f830");
    check("f830_is_7", 32'(sweep_count), 32'd7);

    // write and eval on the same address in one cycle
    in_valid  = 1'b1;
    in_vec    = 4'd5;
    cfg_we    = 1'b1;
    cfg_addr  = 4'd5;
    cfg_data  = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    check("coll_old_f", 32'(out_f), 32'(mtt[5]));
    mtt[5] = 1'b0;
    tick();
    eval1(4'd5, "coll_new");

    // randomized traffic against a transaction-level model
    mv = 1'b0;
    mf = 1'b0;
    for (int n = 0; n < 150; n++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = 4'($urandom_range(0, 15));
      cfg_data  = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_rdy = !mv || out_ready;
      check("rnd_ready", 32'(in_ready), 32'(m_rdy));
      if (in_valid && m_rdy) begin
        mv = 1'b1;
        mf = mtt[in_vec];
      end else if (out_ready) begin
        mv = 1'b0;
      end
      if (cfg_we) mtt[cfg_addr] = cfg_data;
      tick();
      check("rnd_valid", 32'(out_valid), 32'(mv));
      if (mv) check("rnd_f", 32'(out_f), 32'(mf));
    end
    cfg_we    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    sweep(1'b0, 4'd0, 1'b0, 1'b0, "sweep_rand");

    load(16'hFFFF);
    sweep(1'b0, 4'd0, 1'b0, 1'b0, "sweep_ones");
    check("ones_is_16", 32'(sweep_count), 32'd16);

    // write with start, then an ignored write mid-sweep
    load(16'hF830);
    sweep(1'b1, 4'd0, 1'b1, 1'b1, "sweep_wr");
    check("wr_is_8", 32'(sweep_count), 32'd8);
    eval1(4'd1, "ignored_wr");
    sweep(1'b0, 4'd0, 1'b0, 1'b0, "sweep_again");
    check("again_is_8", 32'(sweep_count), 32'd8);

    // reset during a sweep
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    mtt = 16'h0000;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(sweep_count), 32'd0);
    tick();
    rst_n = 1'b1;
    f_ref = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sweep_done) f_ref = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(f_ref), 32'd0);
    eval1(4'd12, "abort_tt_init");
    sweep(1'b0, 4'd0, 1'b0, 1'b0, "sweep_init");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
